// File: rtl/sum_accumulator.sv
// sum_accumulator: adds each beat of an operand packet into a running sum
// through a ripple-carry adder and presents the sum, a sticky overflow flag
// and the beat count on a valid/ready result handshake.
// Optional feature macro: SUM_ACCUMULATOR_SATURATE_EN (clamp the sum to
// all-ones on carry out instead of wrapping).
module sum_accumulator #(
  parameter int SIZE  = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SIZE-1:0]  acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SIZE-1:0]  rawSum;
  logic             carryOut;
  logic             beatFire;
  logic             resultFire;

  // Ripple-carry adder: acc + in_data with carry-in 0, bit by bit.
  always_comb begin
    logic ripple;
    rawSum = '0;
    ripple = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      rawSum[i] = acc_q[i] ^ in_data[i] ^ ripple;
      ripple    = (acc_q[i] & in_data[i]) | (ripple & (acc_q[i] ^ in_data[i]));
    end
    carryOut = ripple;
  end

  assign beatFire   = in_valid  & (state_q == ACCUM);
  assign resultFire = out_ready & (state_q == DONE);

  // Next-state logic: accumulate beats in ACCUM, hold the result in DONE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (beatFire) begin
`ifdef SUM_ACCUMULATOR_SATURATE_EN
      acc_d = carryOut ? {SIZE{1'b1}} : rawSum;
`else
      acc_d = rawSum;
`endif
      ovf_d = ovf_q | carryOut;
      cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
      if (in_last) begin
        state_d = DONE;
      end
    end else if (resultFire) begin
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
      state_d = ACCUM;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: directed and randomized packets for sum_accumulator,
// checked against a packet-level arithmetic model.
module tb_sum_accumulator;

  localparam int SIZE  = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [SIZE-1:0]  in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [SIZE-1:0]  out_sum;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  int checks = 0;
  int errors = 0;
  int pkt[$];

  sum_accumulator #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Packet-level reference: the true total of all beats decides the result.
  // Any carry happened exactly when the true total exceeds the sum range.
  function automatic void modelPacket(output int expSum, output int expOvf, output int expCnt);
    int total;
    total = 0;
    foreach (pkt[i]) total += pkt[i];
    expOvf = (total > 255) ? 1 : 0;
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    expSum = (total > 255) ? 255 : total;
`else
    expSum = total % 256;
`endif
    expCnt = (pkt.size() > 15) ? 15 : pkt.size();
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse reset low for the given number of cycles; returns at a falling edge.
  task automatic doReset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
    pkt.delete();
  endtask

  // Present one beat, wait (bounded) until it is accepted; returns at a falling edge.
  task automatic applyStimulus(input logic [SIZE-1:0] d, input logic last);
    int waitCycles;
    waitCycles = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    pkt.push_back(int'(d));
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called right after the last beat: result must already be valid, stay
  // stable while held off, then hand over and reopen the input next cycle.
  task automatic finishPacket(input string tag, input int expSum, input int expOvf,
                              input int expCnt, input int holdCycles);
    checkOutput({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    checkOutput({tag, "_sum"},   {24'b0, out_sum},   expSum);
    checkOutput({tag, "_ovf"},   {31'b0, out_ovf},   expOvf);
    checkOutput({tag, "_count"}, {28'b0, out_count}, expCnt);
    checkOutput({tag, "_inrdy_low"}, {31'b0, in_ready}, 32'd0);
    repeat (holdCycles) begin
      @(negedge clk);
      checkOutput({tag, "_hold_sum"},   {24'b0, out_sum},   expSum);
      checkOutput({tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_inrdy_after"}, {31'b0, in_ready},  32'd1);
    checkOutput({tag, "_valid_after"}, {31'b0, out_valid}, 32'd0);
    checkOutput({tag, "_sum_clear"},   {24'b0, out_sum},   32'd0);
    pkt.delete();
  endtask

  initial begin
    int expSum, expOvf, expCnt, len;
    logic [SIZE-1:0] d;

    // Reset state
    doReset(2);
    checkOutput("rst_in_ready",  {31'b0, in_ready},  32'd1);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_sum",       {24'b0, out_sum},   32'd0);
    checkOutput("rst_ovf",       {31'b0, out_ovf},   32'd0);
    checkOutput("rst_count",     {28'b0, out_count}, 32'd0);

    // Basic packet with out_ready already high during accumulation
    out_ready = 1'b1;
    applyStimulus(8'h03, 1'b0);
    applyStimulus(8'h05, 1'b0);
    checkOutput("accum_no_valid", {31'b0, out_valid}, 32'd0);
    applyStimulus(8'h07, 1'b1);
    out_ready = 1'b0;
    finishPacket("pkt3", 32'h0F, 0, 3, 0);

    // Overflow packet
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h20, 1'b1);
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    finishPacket("ovf", 32'hFF, 1, 2, 1);
`else
    finishPacket("ovf", 32'h10, 1, 2, 1);
`endif

    // Wrap boundary
    applyStimulus(8'hFF, 1'b0);
    applyStimulus(8'h01, 1'b1);
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    finishPacket("wrap", 32'hFF, 1, 2, 0);
`else
    finishPacket("wrap", 32'h00, 1, 2, 0);
`endif

    // Backpressure: beats offered while DONE must be ignored
    applyStimulus(8'h11, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 8'h22;
      in_last  = 1'b1;
      @(negedge clk);
      checkOutput("bp_in_ready", {31'b0, in_ready},  32'd0);
      checkOutput("bp_sum",      {24'b0, out_sum},   32'h11);
      checkOutput("bp_count",    {28'b0, out_count}, 32'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    finishPacket("bp", 32'h11, 0, 1, 0);

    // Reset mid-packet discards the partial sum
    applyStimulus(8'h10, 1'b0);
    applyStimulus(8'h20, 1'b0);
    doReset(1);
    applyStimulus(8'h01, 1'b1);
    finishPacket("midrst", 32'h01, 0, 1, 0);

    // Reset while DONE discards the pending result
    applyStimulus(8'h44, 1'b1);
    doReset(1);
    checkOutput("donerst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("donerst_sum",   {24'b0, out_sum},   32'd0);

    // Count saturation
    for (int i = 0; i < 17; i++) applyStimulus(8'h00, (i == 16));
    finishPacket("cntsat", 32'h00, 0, 15, 0);

    // Randomized packets against the model
    for (int p = 0; p < 25; p++) begin
      len = $urandom_range(1, 20);
      for (int b = 0; b < len; b++) begin
        d = (p % 2 == 0) ? SIZE'($urandom_range(0, 31)) : SIZE'($urandom_range(0, 255));
        applyStimulus(d, (b == len - 1));
      end
      modelPacket(expSum, expOvf, expCnt);
      finishPacket("rand", expSum, expOvf, expCnt, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Sequential stage downstream of the team's 8-bit ripple-carry adder.
- Accepts a packet of operands over a valid/ready stream and adds each beat into a running sum using the adder datapath.
- Presents the final sum, a sticky overflow flag and a beat count on an output valid/ready handshake.
- Lab datapath block between the operand source and the result display/checker.

Parameters:
- SIZE, 8, operand and sum width in bits.
- CNT_W, 4, width of the beat counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  SIZE  operand.
- in_last  input  1  marks the final beat of a packet; qualified by in_valid.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  SIZE  accumulated sum.
- out_ovf  output  1  sticky flag: at least one carry out of bit SIZE-1 occurred during the packet.
- out_count  output  CNT_W  number of beats accepted in the packet.

Behaviour:
- One clock (clk). Reset is synchronous, active-low (rst_n); no asynchronous paths.
- States: ACCUM (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1). Both are registered.
- Reset (rst_n=0 at a rising edge) gives state ACCUM, acc=0, ovf=0, cnt=0. Outputs after reset: in_ready=1, out_valid=0, out_sum=0, out_ovf=0, out_count=0.
- Beat acceptance: in_valid & in_ready at a rising edge.
  - {c, acc} <= acc + in_data, carry-in 0, SIZE-bit wrap-around.
  - ovf <= ovf | c.
  - cnt <= cnt + 1, saturating at 2^CNT_W-1.
- Accepted beat with in_last=1: the state goes to DONE on the same edge. out_valid is asserted the cycle after the last beat (latency 1), and out_sum already includes that beat.
- out_sum, out_ovf and out_count are driven directly from acc, ovf and cnt. They are valid and stable only while out_valid=1.
- DONE:
  - Holds all outputs stable until out_ready=1.
  - On out_valid & out_ready at a rising edge: acc, ovf and cnt clear to 0 and the state returns to ACCUM.
  - in_ready rises the cycle after the handshake. There is no same-cycle bypass.
- in_valid while in_ready=0 is ignored. Upstream must hold its beat until in_ready=1.
- Single-beat packets (first beat has in_last=1) are legal: count=1.
- Wrap example: acc=0xFF plus in_data=0x01 gives acc=0x00 and ovf=1.
- Reset mid-packet or during DONE discards the partial or pending result. No output handshake completes.
- out_ready asserted while in ACCUM has no effect.

Optional Feature:
- Macro: SUM_ACCUMULATOR_SATURATE_EN.
- Defined: on any carry out, acc <= all-ones (2^SIZE-1) instead of the wrapped value. Once saturated, acc stays all-ones for the rest of the packet. ovf is still set.
- Undefined: plain modulo-2^SIZE wrap-around as described in Behaviour.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then 1 -> in_ready=1, out_valid=0, out_sum=0x00, out_ovf=0, out_count=0.
- Packet 0x03, 0x05, 0x07 (last), out_ready=1 -> out_valid=1 one cycle after the last beat with out_sum=0x0F, out_ovf=0, out_count=3; in_ready=1 the cycle after the handshake.
- Packet 0xF0, 0x20 (last) -> out_sum=0x10, out_ovf=1, out_count=2. With SUM_ACCUMULATOR_SATURATE_EN: out_sum=0xFF, out_ovf=1.
- Backpressure: after packet 0x11 (last), hold out_ready=0 for 5 cycles while pulsing in_valid with 0x22 -> out_sum stays 0x11, in_ready=0, the 0x22 beats are not accepted; raising out_ready completes the handshake.
- Reset mid-packet: accept 0x10, 0x20, pulse rst_n=0 for 1 cycle, then send 0x01 (last) -> out_sum=0x01, out_count=1, out_ovf=0.
- Count saturation: 17 beats of 0x00, the last with in_last=1 -> out_count=15, out_sum=0x00, out_ovf=0.
